// File: rtl/gc.sv
// Global constants shared by the IO slot front ends and the IO arbiter.
package gc;
  localparam int WORD_SIZE = 16;
  localparam logic IO_OUT = 1'b0;  // read from memory: port does not drive the shared bus
  localparam logic IO_IN  = 1'b1;  // write to memory
endpackage

// File: rtl/io_request_port_if.sv
// Device/arbiter signal bundle for one io_request_port slot; slave = the port, master = its environment.
interface io_request_port_if #(
  parameter int WORD_SIZE = gc::WORD_SIZE
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic [WORD_SIZE-1:0] arb_addr;
  logic [WORD_SIZE-1:0] arb_wdata;
  logic                 arb_dir;
  logic                 arb_grant;
  logic [WORD_SIZE-1:0] arb_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, arb_grant, arb_rdata,
    output req_ready, rsp_valid, rsp_rdata, arb_addr, arb_wdata, arb_dir
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, arb_grant, arb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, arb_addr, arb_wdata, arb_dir
  );
endinterface

// File: rtl/io_request_port.sv
// Per-slot IO request queue in front of the IO arbiter: in-order FIFO, grant tracking, read response register.
// Optional grant-wait watchdog enabled by defining IO_PORT_TIMEOUT_EN.
module io_request_port #(
  parameter int WORD_SIZE      = gc::WORD_SIZE,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  io_request_port_if.slave        bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("io_request_port: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic                 write;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    RSP_HOLD
  } state_e;

  req_t                 mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  state_e               state_q, state_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic capture;
  req_t head;
  req_t push_entry;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LVL_W'(DEPTH));
  assign push       = bus.req_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign push_entry = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    if (bus.rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      WAIT_SLOT: begin
        if (bus.arb_grant && !empty) begin
          if (head.write) begin
            pop = 1'b1;
          end else if (!rsp_valid_q || bus.rsp_ready) begin
            pop     = 1'b1;
            capture = 1'b1;
          end else begin
            // Response register still owned by the device: this grant is forfeited.
            state_d = RSP_HOLD;
          end
        end
      end
      RSP_HOLD: begin
        if (rsp_valid_q && bus.rsp_ready) state_d = WAIT_SLOT;
      end
      default: ;
    endcase

    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = bus.arb_rdata;
    end

    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // Outside RSP_HOLD the state simply follows whether anything remains queued.
    if (state_d != RSP_HOLD) state_d = (level_d == '0) ? IDLE : WAIT_SLOT;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible through level-qualified head logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.req_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.arb_addr  = empty ? '0 : head.addr;
  assign bus.arb_wdata = empty ? '0 : head.wdata;
  assign bus.arb_dir   = (!empty && head.write) ? gc::IO_IN : gc::IO_OUT;
  assign level         = level_q;

`ifdef IO_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // An ungranted WAIT_SLOT cycle can never leave WAIT_SLOT, so grant/state alone decide the clear.
  always_comb begin
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q;
    if (state_q == WAIT_SLOT && !bus.arb_grant) begin
      wait_cnt_d = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES)) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_request_port.sv
// Directed self-checking bench for io_request_port (DEPTH = 4, TIMEOUT_CYCLES = 8).
module tb_io_request_port;

  localparam int W = gc::WORD_SIZE;
`ifdef IO_PORT_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] level;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  io_request_port_if #(.WORD_SIZE(W)) bus ();

  io_request_port #(
    .WORD_SIZE      (W),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .level       (level),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic write, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic push(input logic write, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    set_req(write, addr, wdata);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic grant(input logic [W-1:0] rdata);
    bus.arb_grant = 1'b1;
    bus.arb_rdata = rdata;
    step();
    bus.arb_grant = 1'b0;
    bus.arb_rdata = 16'hDEAD;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.arb_grant = 1'b0;
    bus.arb_rdata = 16'hDEAD;
    repeat (2) step();

    check("rst_level", level, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_arb_dir", bus.arb_dir, gc::IO_OUT);
    check("rst_arb_addr", bus.arb_addr, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    step();

    // Write then read the same address, grants every 4th cycle.
    push(1'b1, 16'h0010, 16'h00AB);
    check("wr_present_dir", bus.arb_dir, gc::IO_IN);
    check("wr_present_addr", bus.arb_addr, 16'h0010);
    check("wr_present_wdata", bus.arb_wdata, 16'h00AB);
    push(1'b0, 16'h0010, 16'h0000);
    check("wr_rd_level", level, 2);
    repeat (2) step();
    check("no_grant_level", level, 2);
    grant(16'hBEEF);
    check("wr_done_level", level, 1);
    check("wr_no_rsp", bus.rsp_valid, 0);
    check("rd_present_dir", bus.arb_dir, gc::IO_OUT);
    check("rd_present_addr", bus.arb_addr, 16'h0010);
    repeat (3) step();
    check("rd_wait_rsp", bus.rsp_valid, 0);
    grant(16'h00AB);
    check("rd_rsp_valid", bus.rsp_valid, 1);
    check("rd_rsp_rdata", bus.rsp_rdata, 16'h00AB);
    check("rd_level_zero", level, 0);
    check("rd_empty_addr", bus.arb_addr, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_consumed", bus.rsp_valid, 0);

    // Fill to DEPTH with no grant; 5th request held off until a pop.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 16'(16'h0020 + i), 16'(16'h0A00 + i));
      check($sformatf("fill_ready_%0d", i), bus.req_ready, 1);
      step();
    end
    set_req(1'b1, 16'h0024, 16'h0A04);
    check("full_not_ready", bus.req_ready, 0);
    check("full_level", level, 4);
    step();
    check("full_no_push", level, 4);
    check("full_head", bus.arb_addr, 16'h0020);
    grant(16'h0000);
    check("full_pop_no_push", level, 3);
    check("full_head2", bus.arb_addr, 16'h0021);
    check("ready_after_pop", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("fifth_pushed", level, 4);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain_addr_%0d", i), bus.arb_addr, 16'(16'h0020 + i));
      check($sformatf("drain_wdata_%0d", i), bus.arb_wdata, 16'(16'h0A00 + i));
      grant(16'h0000);
    end
    check("drain_level1", level, 1);
    check("drain_head_wrap", bus.arb_addr, 16'h0024);
    set_req(1'b1, 16'h0030, 16'h0B00);
    grant(16'h0000);
    bus.req_valid = 1'b0;
    check("push_pop_level", level, 1);
    check("push_pop_head", bus.arb_addr, 16'h0030);
    grant(16'h0000);
    check("fill_done_level", level, 0);

    // Response back-pressure: second read grant lost while rsp register is full.
    push(1'b0, 16'h0040, 16'h0000);
    push(1'b0, 16'h0044, 16'h0000);
    grant(16'h1111);
    check("bp_first_valid", bus.rsp_valid, 1);
    check("bp_first_data", bus.rsp_rdata, 16'h1111);
    check("bp_first_level", level, 1);
    grant(16'h2222);
    check("bp_lost_level", level, 1);
    check("bp_lost_data", bus.rsp_rdata, 16'h1111);
    check("bp_hold_head", bus.arb_addr, 16'h0044);
    grant(16'h2222);
    check("bp_hold_ignores", level, 1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("bp_drained", bus.rsp_valid, 0);
    check("bp_still_queued", level, 1);
    grant(16'h2222);
    check("bp_second_valid", bus.rsp_valid, 1);
    check("bp_second_data", bus.rsp_rdata, 16'h2222);
    check("bp_second_level", level, 0);
    push(1'b0, 16'h0048, 16'h0000);
    bus.rsp_ready = 1'b1;
    grant(16'h3333);
    check("b2b_valid", bus.rsp_valid, 1);
    check("b2b_data", bus.rsp_rdata, 16'h3333);
    step();
    bus.rsp_ready = 1'b0;
    check("b2b_consumed", bus.rsp_valid, 0);

    // Idle bus safety: grants on an empty FIFO are ignored.
    for (int i = 0; i < 4; i++) begin
      grant(16'h5555);
      check($sformatf("idle_dir_%0d", i), bus.arb_dir, gc::IO_OUT);
      check($sformatf("idle_addr_%0d", i), bus.arb_addr, 0);
      check($sformatf("idle_rsp_%0d", i), bus.rsp_valid, 0);
      check($sformatf("idle_level_%0d", i), level, 0);
    end

    // Asynchronous reset with 3 queued entries and a pending response.
    push(1'b0, 16'h0050, 16'h0000);
    grant(16'h6666);
    push(1'b1, 16'h0060, 16'h0C00);
    push(1'b1, 16'h0061, 16'h0C01);
    push(1'b1, 16'h0062, 16'h0C02);
    check("pre_rst_level", level, 3);
    check("pre_rst_rsp", bus.rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_rsp_valid", bus.rsp_valid, 0);
    check("async_rst_rsp_rdata", bus.rsp_rdata, 0);
    check("async_rst_addr", bus.arb_addr, 0);
    check("async_rst_dir", bus.arb_dir, gc::IO_OUT);
    step();
    rst = 1'b0;
    step();
    check("post_rst_level", level, 0);
    check("post_rst_ready", bus.req_ready, 1);

    // Grant-wait watchdog: no grant for 10 cycles, then completion.
    push(1'b1, 16'h0070, 16'h0D00);
    repeat (7) step();
    check("to_before_limit", timeout_err, 0);
    step();
    check("to_at_limit", timeout_err, 32'(EXP_TO));
    repeat (2) step();
    check("to_still_queued", level, 1);
    grant(16'h0000);
    check("to_completed", level, 0);
    check("to_sticky", timeout_err, 32'(EXP_TO));
    repeat (3) step();
    check("to_sticky_later", timeout_err, 32'(EXP_TO));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
